// File: rtl/ippro_input_stream_fifo_pkg.sv
// Shared constants and types for the IPPro input stream FIFO.
// The constants carry the same values as the codebase-wide
// FIFO_datasize / IN_FIFO_DEPTH_LOG2 / IN_FIFO_AF_THRESH defines, so the
// FIFO and the core agree on word width and depth.
package ippro_input_stream_fifo_pkg;

  // Pixel word width shared with the core datapath.
  localparam int FIFO_DATASIZE      = 16;

  // log2 of the input FIFO depth (512 words).
  localparam int IN_FIFO_DEPTH_LOG2 = 9;

  // Occupancy at and above which ALMOST_FULL is raised.
  localparam int IN_FIFO_AF_THRESH  = 508;

  // Transfers resolved for one clock edge. Everything that happens at an
  // edge is described by these four bits, which keeps the next-state logic
  // readable and makes the flush priority explicit in one place.
  typedef struct packed {
    logic flush;     // contents are being discarded this edge
    logic push;      // upstream word accepted this edge
    logic pop;       // word transferred from storage to DOUT this edge
    logic underflow; // READ_EN seen while EMPTY this edge
  } fifo_xfer_t;

endpackage : ippro_input_stream_fifo_pkg

// File: rtl/ippro_input_stream_fifo_ram.sv
// Simple dual-port storage for the input stream FIFO.
// One synchronous write port and one read port with a registered output
// and read enable, so the output register doubles as the FIFO's DOUT and
// holds its value between pops. The array is written without a reset so
// it maps onto block or distributed RAM.
module ippro_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Write port: store the accepted word at the edge.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: the output register only loads on a pop, otherwise it holds.
  // Only this register is reset so DOUT starts at zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule : ippro_fifo_ram

// File: rtl/ippro_input_stream_fifo.sv
// Input stream buffer in front of the IPPro single-core datapath.
// Upstream pixels arrive over S_VALID/S_READY; the core pulls them through
// its GET interface (READ_EN/DOUT/EMPTY) with one cycle of read latency.
// Pointers carry an extra MSB so full and empty are distinguishable
// without a separate occupancy comparison. All status outputs are
// registered and describe the FIFO after the previous edge's transfers.
module ippro_input_stream_fifo
  import ippro_input_stream_fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATASIZE,
  parameter int DEPTH_LOG2 = IN_FIFO_DEPTH_LOG2,
  parameter int AF_THRESH  = IN_FIFO_AF_THRESH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_W-1:0]     S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic                  FLUSH,
  input  logic                  READ_EN,
  output logic [DATA_W-1:0]     DOUT,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  UNDERFLOW
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Registered state.
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] count_reg;
  logic             empty_reg;
  logic             s_ready_reg;
  logic             almost_full_reg;
  logic             underflow_reg;

  // Next-state values.
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] count_next;
  logic             empty_next;
  logic             full_next;
  logic             almost_full_next;
  logic             underflow_next;

  fifo_xfer_t       xfer;

  // Resolve this edge's transfers. FLUSH drops any push or pop, and the
  // push is gated by the registered S_READY only: a same-cycle pop on a
  // full FIFO does not open a slot until the next cycle. The pop is gated
  // by the registered EMPTY, which also guarantees the read address never
  // points at a slot being written for the first time this edge.
  always_comb begin
    xfer           = '0;
    xfer.flush     = FLUSH;
    xfer.push      = S_VALID & s_ready_reg & ~FLUSH;
    xfer.pop       = READ_EN & ~empty_reg & ~FLUSH;
    xfer.underflow = READ_EN & empty_reg & ~FLUSH;
  end

  // Next pointers, occupancy and flags derived from the post-edge pointers.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    underflow_next   = underflow_reg;

    if (xfer.flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      underflow_next = 1'b0;
    end else begin
      if (xfer.push) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (xfer.pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      if (xfer.underflow) begin
        underflow_next = 1'b1;
      end
    end

    // Pointer difference modulo 2*DEPTH is the occupancy, 0..DEPTH.
    count_next       = wr_ptr_next - rd_ptr_next;
    empty_next       = (wr_ptr_next == rd_ptr_next);
    full_next        = (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                       (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);
    almost_full_next = (count_next >= AF_LEVEL);
  end

  // State register. RESET wins over everything, including FLUSH, and holds
  // S_READY low for as long as it is asserted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      empty_reg       <= 1'b1;
      s_ready_reg     <= 1'b0;
      almost_full_reg <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      empty_reg       <= empty_next;
      s_ready_reg     <= ~full_next;
      almost_full_reg <= almost_full_next;
      underflow_reg   <= underflow_next;
    end
  end

  // Storage; its registered read output is DOUT, so DOUT is held across
  // flushes and idle cycles and cleared only by RESET.
  ippro_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (xfer.push & ~RESET),
    .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
    .wr_data (S_DATA),
    .rd_en   (xfer.pop & ~RESET),
    .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
    .rd_data (DOUT)
  );

  assign S_READY     = s_ready_reg;
  assign EMPTY       = empty_reg;
  assign ALMOST_FULL = almost_full_reg;
  assign COUNT       = count_reg;
  assign UNDERFLOW   = underflow_reg;

endmodule : ippro_input_stream_fifo

// File: tb/tb_ippro_input_stream_fifo.sv
// Self-checking bench for ippro_input_stream_fifo: a directed vector table,
// hand-written corner sequences and a randomized run, all compared against
// a queue-based reference model of the FIFO's visible behaviour.
module tb_ippro_input_stream_fifo;

  localparam int DW    = 16;
  localparam int DL2   = 9;
  localparam int DEPTH = 512;
  localparam int AFT   = 508;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic          FLUSH;
  logic          READ_EN;
  logic [DW-1:0] DOUT;
  logic          EMPTY;
  logic          ALMOST_FULL;
  logic [DL2:0]  COUNT;
  logic          UNDERFLOW;

  int checks   = 0;
  int failures = 0;

  // Reference model state: stored words, last popped word, sticky flag.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_uf;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          re;
    logic          fl;
    int            cnt;
    logic          emp;
    logic [DW-1:0] dout;
    logic          uf;
  } vec_t;

  vec_t vecs[7];

  always #5 CLK = ~CLK;

  ippro_input_stream_fifo #(
    .DATA_W     (DW),
    .DEPTH_LOG2 (DL2),
    .AF_THRESH  (AFT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .S_DATA      (S_DATA),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .FLUSH       (FLUSH),
    .READ_EN     (READ_EN),
    .DOUT        (DOUT),
    .EMPTY       (EMPTY),
    .ALMOST_FULL (ALMOST_FULL),
    .COUNT       (COUNT),
    .UNDERFLOW   (UNDERFLOW)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One edge of the reference model from the rules: flush empties the
  // store and clears the sticky flag; otherwise a pop needs a stored word,
  // a push needs a free slot counted before this edge's pop.
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic re, input logic fl);
    int pre;
    pre = mq.size();
    if (fl) begin
      mq.delete();
      m_uf = 1'b0;
    end else begin
      if (re && pre == 0) m_uf = 1'b1;
      if (re && pre > 0) m_dout = mq.pop_front();
      if (v && pre < DEPTH) mq.push_back(d);
    end
  endtask

  task automatic drive_edge(input logic v, input logic [DW-1:0] d, input logic re, input logic fl);
    S_VALID = v;
    S_DATA  = d;
    READ_EN = re;
    FLUSH   = fl;
    model_step(v, d, re, fl);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    check({tag, "_count"},   32'(COUNT),       32'(n));
    check({tag, "_empty"},   32'(EMPTY),       32'(n == 0));
    check({tag, "_af"},      32'(ALMOST_FULL), 32'(n >= AFT));
    check({tag, "_sready"},  32'(S_READY),     32'(n < DEPTH));
    check({tag, "_uflow"},   32'(UNDERFLOW),   32'(m_uf));
    check({tag, "_dout"},    32'(DOUT),        32'(m_dout));
  endtask

  task automatic do_reset(input logic fl_during);
    RESET   = 1'b1;
    S_VALID = 1'b1;
    S_DATA  = 16'hffff;
    READ_EN = 1'b1;
    FLUSH   = fl_during;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("reset_sready_low", 32'(S_READY), 32'd0);
    RESET   = 1'b0;
    S_VALID = 1'b0;
    READ_EN = 1'b0;
    FLUSH   = 1'b0;
    @(posedge CLK);
    #1;
    mq.delete();
    m_dout = '0;
    m_uf   = 1'b0;
    check("reset_count",  32'(COUNT),       32'd0);
    check("reset_empty",  32'(EMPTY),       32'd1);
    check("reset_af",     32'(ALMOST_FULL), 32'd0);
    check("reset_uflow",  32'(UNDERFLOW),   32'd0);
    check("reset_dout",   32'(DOUT),        32'd0);
    check("reset_sready", 32'(S_READY),     32'd1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int            pushed;

    // Directed vectors: push three words, then pop them one by one.
    vecs[0] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 16'h0022, 1'b0, 1'b0, 2, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 16'h0033, 1'b0, 1'b0, 3, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 16'h0011, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 16'h0022, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h0033, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 16'h0033, 1'b0};

    m_dout = '0;
    m_uf   = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 7; i++) begin
      drive_edge(vecs[i].v, vecs[i].d, vecs[i].re, vecs[i].fl);
      check($sformatf("vec%0d_count", i), 32'(COUNT),     32'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 32'(EMPTY),     32'(vecs[i].emp));
      check($sformatf("vec%0d_dout", i),  32'(DOUT),      32'(vecs[i].dout));
      check($sformatf("vec%0d_uflow", i), 32'(UNDERFLOW), 32'(vecs[i].uf));
      $display("vec %0d: count=%0d empty=%0b dout=%04h", i, COUNT, EMPTY, DOUT);
    end

    // Fill to 512 with no reads, watching the almost-full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      drive_edge(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
      check_model("fill");
      if (i == AFT - 2) check("fill_af_507", 32'(ALMOST_FULL), 32'd0);
      if (i == AFT - 1) check("fill_af_508", 32'(ALMOST_FULL), 32'd1);
    end
    $display("fill: count=%0d sready=%0b af=%0b", COUNT, S_READY, ALMOST_FULL);
    check("full_sready", 32'(S_READY), 32'd0);
    drive_edge(1'b1, 16'hdead, 1'b0, 1'b0);
    check("full_513th_count", 32'(COUNT), 32'(DEPTH));
    check_model("full_hold");
    // Pop at full with a push offered: the push is refused this edge.
    drive_edge(1'b1, 16'hdeaf, 1'b1, 1'b0);
    check("full_pop_count", 32'(COUNT), 32'(DEPTH - 1));
    check("full_pop_sready", 32'(S_READY), 32'd1);
    check("full_pop_dout", 32'(DOUT), 32'h2000);
    check_model("full_pop");

    // Drain down to 10 words.
    while (mq.size() > 10) begin
      drive_edge(1'b0, 16'h0000, 1'b1, 1'b0);
      check_model("drain");
    end

    // Sustained push+pop at occupancy 10.
    for (int i = 0; i < 1000; i++) begin
      drive_edge(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);
      check_model("stream");
    end
    check("stream_count", 32'(COUNT), 32'd10);
    check("stream_last_dout", 32'(DOUT), 32'(16'h1000 + 989));
    $display("stream: count=%0d dout=%04h", COUNT, DOUT);

    while (mq.size() > 0) begin
      drive_edge(1'b0, 16'h0000, 1'b1, 1'b0);
      check_model("drain2");
    end

    // Underflow: sticky, DOUT held, then cleared by FLUSH.
    held = DOUT;
    drive_edge(1'b0, 16'h0000, 1'b1, 1'b0);
    check("uf_set", 32'(UNDERFLOW), 32'd1);
    check("uf_dout", 32'(DOUT), 32'(held));
    check("uf_count", 32'(COUNT), 32'd0);
    repeat (3) begin
      drive_edge(1'b0, 16'h0000, 1'b0, 1'b0);
      check("uf_held", 32'(UNDERFLOW), 32'd1);
    end
    drive_edge(1'b0, 16'h0000, 1'b0, 1'b1);
    check("uf_flush_clear", 32'(UNDERFLOW), 32'd0);
    $display("underflow: uflow=%0b dout=%04h", UNDERFLOW, DOUT);

    // Flush at COUNT=5 together with a push and a READ_EN.
    for (int i = 0; i < 5; i++) drive_edge(1'b1, 16'(16'h0501 + i), 1'b0, 1'b0);
    check("flush_pre_count", 32'(COUNT), 32'd5);
    held = DOUT;
    drive_edge(1'b1, 16'hbeef, 1'b1, 1'b1);
    check("flush_count", 32'(COUNT), 32'd0);
    check("flush_empty", 32'(EMPTY), 32'd1);
    check("flush_dout", 32'(DOUT), 32'(held));
    check("flush_sready", 32'(S_READY), 32'd1);
    drive_edge(1'b1, 16'h7777, 1'b0, 1'b0);
    drive_edge(1'b0, 16'h0000, 1'b1, 1'b0);
    check("flush_next_word", 32'(DOUT), 32'h7777);
    check_model("flush_after");
    $display("flush: count=%0d dout=%04h", COUNT, DOUT);

    // Mid-stream reset with FLUSH also asserted.
    for (int i = 0; i < 4; i++) drive_edge(1'b1, 16'(16'h0a00 + i), 1'b0, 1'b0);
    do_reset(1'b1);
    drive_edge(1'b1, 16'habcd, 1'b0, 1'b0);
    drive_edge(1'b0, 16'h0000, 1'b1, 1'b0);
    check("midreset_word", 32'(DOUT), 32'habcd);
    check_model("midreset");

    // Randomized wrap-around run, phases biased toward filling and draining.
    pushed = 0;
    for (int cyc = 0; cyc < 20000 && pushed < 3 * DEPTH; cyc++) begin
      int   ph;
      logic v;
      logic re;
      ph = (cyc / 900) % 3;
      v  = ($urandom_range(0, 99) < (ph == 0 ? 85 : (ph == 1 ? 25 : 55)));
      re = ($urandom_range(0, 99) < (ph == 0 ? 25 : (ph == 1 ? 85 : 55)));
      if (v && mq.size() < DEPTH) pushed++;
      drive_edge(v, 16'($urandom), re, 1'b0);
      check_model("rand");
    end
    check("rand_words_pushed", 32'(pushed >= 3 * DEPTH), 32'd1);
    $display("random: pushed=%0d count=%0d", pushed, COUNT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ippro_input_stream_fifo
